// File: rtl/data_bus_if_pkg.sv
// Shared definitions for the Wishbone data/instruction bus bridges: FSM states, constants, defaults.
package data_bus_if_pkg;

    typedef enum logic [1:0] {
        WB_IDLE       = 2'd0,
        WB_BUSY       = 2'd1,
        WB_WAIT_STALL = 2'd2
    } wb_state_t;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;
    localparam logic        Stop     = 1'b1;
    localparam logic        NoStop   = 1'b0;

    localparam int TIMEOUT_DEF = 64;
    localparam int CNT_W_DEF   = 8;

endpackage

// File: rtl/data_bus_if_if.sv
// Pipeline-side request/response plus Wishbone B3 classic master signals of one bus bridge.
interface data_bus_if_if;

    logic [5:0]  stall;
    logic        flush;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        stallreq;
    logic        bus_err_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    modport master (
        input  stall, flush, cpu_ce_i, cpu_we_i, cpu_addr_i, cpu_sel_i, cpu_data_i,
        input  wb_dat_i, wb_ack_i,
        output cpu_data_o, stallreq, bus_err_o,
        output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
    );

    modport slave (
        output stall, flush, cpu_ce_i, cpu_we_i, cpu_addr_i, cpu_sel_i, cpu_data_i,
        output wb_dat_i, wb_ack_i,
        input  cpu_data_o, stallreq, bus_err_o,
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
    );

endinterface

// File: rtl/data_bus_if.sv
// MEM-stage to Wishbone classic bridge: request accepted in cycle N, bus cycle from N+1, data to MEM in the ack cycle.
// Backpressure: stallreq holds the pipeline until ack; a frozen pipeline sees the read result held from rd_buf.
module data_bus_if
    import data_bus_if_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    data_bus_if_if.master bus
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MaxCnt  = '1;

    wb_state_t        r_state, w_state_nxt;
    logic [31:0]      r_adr, w_adr_nxt;
    logic [31:0]      r_dat, w_dat_nxt;
    logic             r_we, w_we_nxt;
    logic [3:0]       r_sel, w_sel_nxt;
    logic             r_cyc, w_cyc_nxt;
    logic [31:0]      r_rd_buf, w_rd_buf_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_bus_err, w_bus_err_nxt;
    logic             w_stallreq;
    logic [31:0]      w_cpu_data;
    logic             w_timeout;

    assign w_timeout = (TIMEOUT != 0) && (r_cnt == LastCnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= WB_IDLE;
            r_adr     <= ZeroWord;
            r_dat     <= ZeroWord;
            r_we      <= 1'b0;
            r_sel     <= 4'b0000;
            r_cyc     <= 1'b0;
            r_rd_buf  <= ZeroWord;
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_adr     <= w_adr_nxt;
            r_dat     <= w_dat_nxt;
            r_we      <= w_we_nxt;
            r_sel     <= w_sel_nxt;
            r_cyc     <= w_cyc_nxt;
            r_rd_buf  <= w_rd_buf_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bus_err <= w_bus_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_adr_nxt     = r_adr;
        w_dat_nxt     = r_dat;
        w_we_nxt      = r_we;
        w_sel_nxt     = r_sel;
        w_cyc_nxt     = r_cyc;
        w_rd_buf_nxt  = r_rd_buf;
        w_cnt_nxt     = r_cnt;
        w_bus_err_nxt = 1'b0;
        w_stallreq    = NoStop;
        w_cpu_data    = ZeroWord;

        unique case (r_state)
            WB_IDLE: begin
                if (bus.cpu_ce_i && !bus.flush) begin
                    w_adr_nxt   = bus.cpu_addr_i;
                    w_dat_nxt   = bus.cpu_data_i;
                    w_we_nxt    = bus.cpu_we_i;
                    w_sel_nxt   = bus.cpu_sel_i;
                    w_cyc_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = WB_BUSY;
                    w_stallreq  = Stop;
                end
            end

            WB_BUSY: begin
                // Ack wins over flush and timeout: the bus side must always see its cycle complete.
                if (bus.wb_ack_i) begin
                    w_adr_nxt = ZeroWord;
                    w_dat_nxt = ZeroWord;
                    w_we_nxt  = 1'b0;
                    w_sel_nxt = 4'b0000;
                    w_cyc_nxt = 1'b0;
                    if (!r_we) begin
                        w_rd_buf_nxt = bus.wb_dat_i;
                        w_cpu_data   = bus.wb_dat_i;
                    end
                    if (bus.flush)
                        w_state_nxt = WB_IDLE;
                    else if (bus.stall != 6'd0)
                        w_state_nxt = WB_WAIT_STALL;
                    else
                        w_state_nxt = WB_IDLE;
                end else if (bus.flush) begin
                    w_adr_nxt    = ZeroWord;
                    w_dat_nxt    = ZeroWord;
                    w_we_nxt     = 1'b0;
                    w_sel_nxt    = 4'b0000;
                    w_cyc_nxt    = 1'b0;
                    w_rd_buf_nxt = ZeroWord;
                    w_state_nxt  = WB_IDLE;
                end else if (w_timeout) begin
                    w_adr_nxt     = ZeroWord;
                    w_dat_nxt     = ZeroWord;
                    w_we_nxt      = 1'b0;
                    w_sel_nxt     = 4'b0000;
                    w_cyc_nxt     = 1'b0;
                    w_bus_err_nxt = 1'b1;
                    w_state_nxt   = WB_IDLE;
                    w_stallreq    = Stop;
                end else begin
                    if (r_cnt != MaxCnt)
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    w_stallreq = Stop;
                end
            end

            WB_WAIT_STALL: begin
                w_cpu_data = r_rd_buf;
                if (bus.flush) begin
                    w_rd_buf_nxt = ZeroWord;
                    w_state_nxt  = WB_IDLE;
                end else if (bus.stall == 6'd0) begin
                    w_state_nxt = WB_IDLE;
                end
            end

            default: begin
                w_state_nxt = WB_IDLE;
            end
        endcase
    end

    assign bus.wb_adr_o   = r_adr;
    assign bus.wb_dat_o   = r_dat;
    assign bus.wb_we_o    = r_we;
    assign bus.wb_sel_o   = r_sel;
    assign bus.wb_cyc_o   = r_cyc;
    assign bus.wb_stb_o   = r_cyc;
    assign bus.bus_err_o  = r_bus_err;
    assign bus.stallreq   = w_stallreq;
    assign bus.cpu_data_o = w_cpu_data;

endmodule

// File: tb/tb_data_bus_if.sv
// Bench for data_bus_if: two instances (TIMEOUT=4 and TIMEOUT=0) share stimulus; a transaction-level model predicts every cycle.
module tb_data_bus_if;
    import data_bus_if_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0, ce = 1'b0, we = 1'b0, ack = 1'b0;
    logic [31:0] adr = '0, wdat = '0, rdat = '0;
    logic [3:0]  sel = '0;

    always #5 clk = ~clk;

    data_bus_if_if ifa ();
    data_bus_if_if ifb ();

    assign ifa.stall = stall;   assign ifb.stall = stall;
    assign ifa.flush = flush;   assign ifb.flush = flush;
    assign ifa.cpu_ce_i = ce;   assign ifb.cpu_ce_i = ce;
    assign ifa.cpu_we_i = we;   assign ifb.cpu_we_i = we;
    assign ifa.cpu_addr_i = adr; assign ifb.cpu_addr_i = adr;
    assign ifa.cpu_sel_i = sel; assign ifb.cpu_sel_i = sel;
    assign ifa.cpu_data_i = wdat; assign ifb.cpu_data_i = wdat;
    assign ifa.wb_dat_i = rdat; assign ifb.wb_dat_i = rdat;
    assign ifa.wb_ack_i = ack;  assign ifb.wb_ack_i = ack;

    data_bus_if #(.TIMEOUT(4), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    data_bus_if #(.TIMEOUT(0), .CNT_W(8)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    wire [104:0] obs_a = {ifa.bus_err_o, ifa.stallreq, ifa.cpu_data_o, ifa.wb_cyc_o, ifa.wb_stb_o,
                          ifa.wb_we_o, ifa.wb_sel_o, ifa.wb_adr_o, ifa.wb_dat_o};
    wire [104:0] obs_b = {ifb.bus_err_o, ifb.stallreq, ifb.cpu_data_o, ifb.wb_cyc_o, ifb.wb_stb_o,
                          ifb.wb_we_o, ifb.wb_sel_o, ifb.wb_adr_o, ifb.wb_dat_o};

    int n_chk = 0, n_pass = 0;

    // Model state: last read data each bridge would hand back while the pipeline is frozen.
    logic [31:0] rb_a = '0, rb_b = '0;

    // Current transaction description.
    logic        t_we, t_fl;
    logic [3:0]  t_sel;
    logic [31:0] t_adr, t_dat, t_rd;
    logic [5:0]  t_stv;
    int          t_d, t_h;

    function automatic logic [104:0] pack(logic err, logic sr, logic [31:0] cd, logic cyc,
                                          logic w, logic [3:0] s, logic [31:0] a, logic [31:0] d);
        return {err, sr, cd, cyc, cyc, w, s, a, d};
    endfunction

    // Expected observation k cycles after the request cycle, for a bridge with timeout T.
    function automatic logic [104:0] exp_txn(int T, int k, logic [31:0] rdb);
        bit timed_out;
        int nw;
        timed_out = (T != 0) && (t_d > T);
        nw = t_fl ? 0 : t_h;
        if (k == 0) return pack(1'b0, 1'b1, '0, 1'b0, 1'b0, '0, '0, '0);
        if (timed_out) begin
            if (k <= T)     return pack(1'b0, 1'b1, '0, 1'b1, t_we, t_sel, t_adr, t_dat);
            if (k == T + 1) return pack(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
            return '0;
        end
        if (k < t_d)  return pack(1'b0, 1'b1, '0, 1'b1, t_we, t_sel, t_adr, t_dat);
        if (k == t_d) return pack(1'b0, 1'b0, t_we ? 32'h0 : t_rd, 1'b1, t_we, t_sel, t_adr, t_dat);
        if (k <= t_d + nw) return pack(1'b0, 1'b0, t_we ? rdb : t_rd, 1'b0, 1'b0, '0, '0, '0);
        return '0;
    endfunction

    task automatic idle_inputs();
        ce = 1'b0; ack = 1'b0; flush = 1'b0; stall = '0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
    endtask

    task automatic run_txn(input string tag, input bit cew);
        int nw, last;
        logic [104:0] ea, eb;
        nw = t_fl ? 0 : t_h;
        last = t_d + t_h + 1;
        for (int k = 0; k <= last; k++) begin
            ce    = (k == 0) || (cew && k > t_d && k <= t_d + nw);
            we    = (k == 0) ? t_we  : 1'($urandom);
            sel   = (k == 0) ? t_sel : 4'($urandom);
            adr   = (k == 0) ? t_adr : $urandom;
            wdat  = (k == 0) ? t_dat : $urandom;
            ack   = (k == t_d);
            rdat  = (k == t_d) ? t_rd : $urandom;
            flush = t_fl && (k == t_d);
            stall = (k >= t_d && k < t_d + t_h) ? t_stv : 6'd0;
            @(negedge clk);
            ea = exp_txn(4, k, rb_a);
            eb = exp_txn(0, k, rb_b);
            n_chk++;
            if (obs_a !== ea) $display("FAIL %s k=%0d dut_a got %h want %h", tag, k, obs_a, ea);
            else n_pass++;
            n_chk++;
            if (obs_b !== eb) $display("FAIL %s k=%0d dut_b got %h want %h", tag, k, obs_b, eb);
            else n_pass++;
            @(posedge clk); #1;
        end
        if (!t_we && t_d <= 4) rb_a = t_rd;
        if (!t_we) rb_b = t_rd;
        idle_inputs();
    endtask

    task automatic set_txn(logic w, logic [3:0] s, logic [31:0] a, logic [31:0] d, logic [31:0] r,
                           int dly, int hold, logic [5:0] stv, logic fl);
        t_we = w; t_sel = s; t_adr = a; t_dat = d; t_rd = r;
        t_d = dly; t_h = hold; t_stv = stv; t_fl = fl;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; ack = 1'b1; rdat = 32'hFFFF_FFFF;
        @(posedge clk); #1; @(posedge clk); #1;
        @(negedge clk);
        n_chk++;
        if (obs_a !== 105'd0 || obs_b !== 105'd0) $display("FAIL reset_state a=%h b=%h want 0", obs_a, obs_b);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_chk++;
        if (obs_a !== 105'd0 || obs_b !== 105'd0) $display("FAIL idle_ack_ignored a=%h b=%h want 0", obs_a, obs_b);
        else n_pass++;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_load();
        set_txn(1'b0, 4'hF, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 3, 0, 6'd0, 1'b0);
        run_txn("load_ack3", 1'b0);
    endtask

    task automatic test_store();
        set_txn(1'b1, 4'b0011, 32'h0000_0040, 32'h0000_A5A5, 32'h5555_AAAA, 1, 0, 6'd0, 1'b0);
        run_txn("store_ack1", 1'b0);
    endtask

    task automatic test_wait_stall();
        set_txn(1'b0, 4'hF, 32'h0000_0100, 32'h0, 32'h1234_5678, 1, 2, 6'b000111, 1'b0);
        run_txn("wait_stall_load", 1'b1);
        set_txn(1'b1, 4'hC, 32'h0000_0104, 32'hCAFE_0000, 32'h0BAD_0BAD, 2, 2, 6'b000011, 1'b0);
        run_txn("wait_stall_store", 1'b1);
    endtask

    task automatic test_ack_flush();
        set_txn(1'b0, 4'hF, 32'h0000_0200, 32'h0, 32'h7777_1111, 2, 2, 6'b001111, 1'b1);
        run_txn("ack_beats_flush", 1'b0);
    endtask

    task automatic test_flush(input int fk);
        logic [104:0] e;
        logic [31:0]  a;
        a = $urandom;
        for (int k = 0; k <= fk + 3; k++) begin
            ce = (k == 0); we = 1'b0; sel = 4'hF; adr = (k == 0) ? a : $urandom; wdat = 32'h0;
            ack = (k == fk + 2); rdat = $urandom; flush = (k == fk); stall = '0;
            @(negedge clk);
            if (k == 0)      e = pack(1'b0, 1'b1, '0, 1'b0, 1'b0, '0, '0, '0);
            else if (k < fk) e = pack(1'b0, 1'b1, '0, 1'b1, 1'b0, 4'hF, a, 32'h0);
            else if (k == fk) e = pack(1'b0, 1'b0, '0, 1'b1, 1'b0, 4'hF, a, 32'h0);
            else             e = '0;
            n_chk++;
            if (obs_a !== e) $display("FAIL flush_at_%0d k=%0d dut_a got %h want %h", fk, k, obs_a, e);
            else n_pass++;
            n_chk++;
            if (obs_b !== e) $display("FAIL flush_at_%0d k=%0d dut_b got %h want %h", fk, k, obs_b, e);
            else n_pass++;
            @(posedge clk); #1;
        end
        rb_a = '0; rb_b = '0;
        idle_inputs();
        // A held store exposes rd_buf, which the flush must have cleared.
        set_txn(1'b1, 4'h1, 32'h0000_0300, 32'h0000_00EE, 32'hFFFF_0000, 1, 2, 6'b000001, 1'b0);
        run_txn("rd_buf_after_flush", 1'b0);
    endtask

    task automatic test_timeout();
        set_txn(1'b0, 4'hF, 32'h0000_0400, 32'h0, 32'hAAAA_5555, 6, 0, 6'd0, 1'b0);
        run_txn("timeout_no_ack", 1'b0);
        set_txn(1'b0, 4'hF, 32'h0000_0404, 32'h0, 32'h0000_4444, 4, 0, 6'd0, 1'b0);
        run_txn("ack_at_last_count", 1'b0);
        set_txn(1'b1, 4'h3, 32'h0000_0408, 32'h1111_2222, 32'h0, 5, 0, 6'd0, 1'b0);
        run_txn("ack_after_timeout", 1'b0);
        set_txn(1'b0, 4'hF, 32'h0000_0500, 32'h0, 32'h3030_3030, 301, 0, 6'd0, 1'b0);
        run_txn("no_timeout_300", 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [104:0] e;
        for (int k = 0; k <= 4; k++) begin
            ce = (k == 0); we = 1'b0; sel = 4'hF; adr = 32'h0000_0600; wdat = '0;
            rst = (k == 2); ack = (k == 2); flush = (k == 2); rdat = 32'h9999_9999; stall = (k == 2) ? 6'h3F : 6'h0;
            @(negedge clk);
            if (k == 0)      e = pack(1'b0, 1'b1, '0, 1'b0, 1'b0, '0, '0, '0);
            else if (k == 1) e = pack(1'b0, 1'b1, '0, 1'b1, 1'b0, 4'hF, 32'h0000_0600, 32'h0);
            else             e = '0;
            if (k != 2) begin
                n_chk++;
                if (obs_a !== e || obs_b !== e) $display("FAIL reset_mid k=%0d a=%h b=%h want %h", k, obs_a, obs_b, e);
                else n_pass++;
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        rb_a = '0; rb_b = '0;
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            set_txn(1'($urandom), 4'($urandom_range(1, 15)), $urandom, $urandom, $urandom,
                    int'($urandom_range(1, 7)), int'($urandom_range(0, 3)),
                    6'($urandom_range(1, 63)), ($urandom_range(0, 5) == 0));
            run_txn("random", 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load();
        test_store();
        test_wait_stall();
        test_ack_flush();
        test_flush(2);
        test_flush(4);
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/data_bus_if.md
Name: data_bus_if

Overview:
- Bridges the MEM stage's single-cycle load/store request onto a Wishbone B3 classic master port.
- Sits between the MEM stage and the data-side bus.
- Stalls the pipeline until the bus acknowledges, then holds the read result stable while the pipeline is frozen.
- Acts as the responder to the MEM stage's memory request and drives the stallreq input of the stall controller that produces the stall/flush vector consumed by the pipeline registers.

Parameters:
- TIMEOUT, 64, cycles in BUSY without ack before the transaction is aborted; 0 disables the timeout.
- CNT_W, 8, width of the timeout counter; TIMEOUT must be < 2**CNT_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- stall  in  6  pipeline stall vector from the controller; bit i=1 freezes stage i
- flush  in  1  pipeline flush (exception/eret)
- cpu_ce_i  in  1  MEM-stage request valid
- cpu_we_i  in  1  1=store, 0=load
- cpu_addr_i  in  32  byte address
- cpu_sel_i  in  4  byte lanes
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data to MEM stage (combinational)
- stallreq  out  1  pipeline stall request (combinational)
- bus_err_o  out  1  one-cycle pulse on timeout abort (registered)
- wb_adr_o  out  32  bus address (registered)
- wb_dat_o  out  32  bus write data (registered)
- wb_we_o  out  1  bus write enable (registered)
- wb_sel_o  out  4  bus byte select (registered)
- wb_stb_o  out  1  strobe (registered)
- wb_cyc_o  out  1  cycle (registered)
- wb_dat_i  in  32  bus read data
- wb_ack_i  in  1  bus acknowledge

Behaviour:
- Reset:
  - state=IDLE.
  - All wb_* outputs 0.
  - rd_buf=0, timeout counter=0, bus_err_o=0.
  - stallreq=0 and cpu_data_o=0 follow from the state.
- State encoding lives in the shared package: IDLE, BUSY, WAIT_STALL.
- IDLE:
  - If cpu_ce_i=1 and flush=0:
    - Register wb_adr_o/dat_o/we_o/sel_o from the cpu_* inputs.
    - Set wb_cyc_o=wb_stb_o=1 and clear the counter.
    - Next state BUSY.
  - stallreq = cpu_ce_i & ~flush (combinational, same cycle as the request).
  - cpu_data_o=0.
- BUSY, evaluated in priority order:
  1. wb_ack_i=1:
     - Drop cyc/stb.
     - Zero adr/dat/we/sel.
     - If wb_we_o=0, rd_buf<=wb_dat_i.
     - Next state: IDLE if flush=1; else WAIT_STALL if stall!=0; else IDLE.
     - Combinational in the same cycle: stallreq=0; cpu_data_o = wb_we_o ? 0 : wb_dat_i.
  2. flush=1:
     - Abort the transaction: drop cyc/stb, zero the bus outputs, rd_buf<=0.
     - Next state IDLE; stallreq=0.
  3. TIMEOUT!=0 and counter==TIMEOUT-1:
     - Abort the transaction and pulse bus_err_o=1 for one cycle (the next cycle).
     - Next state IDLE.
     - stallreq=1 in this cycle; cpu_data_o=0.
  4. Otherwise:
     - counter+1, saturating at 2**CNT_W-1.
     - stallreq=1, cpu_data_o=0.
- WAIT_STALL:
  - stallreq=0; cpu_data_o=rd_buf.
  - stall==0 → IDLE, rd_buf kept.
  - flush=1 → IDLE, rd_buf<=0.
  - A new cpu_ce_i is ignored until the state returns to IDLE.
- Bus protocol rules:
  - cyc and stb always equal.
  - Request fields are stable from cyc rise to ack.
  - No new cycle starts in the cycle ack is seen; the minimum idle gap is 1 cycle.
- Latency:
  - Request accepted in cycle N.
  - Earliest ack in cycle N+1; data returned to MEM combinationally in the ack cycle.
- Reset mid-transaction drops cyc/stb immediately at the next edge; a late ack in IDLE is ignored.
- Simultaneous events:
  - Ack beats flush and timeout: the bus side completes, and the CPU side discards the result if flush=1.
  - Flush beats timeout: no bus_err_o.

Decomposition:
- Shared package (defines file): state encodings, WB_IDLE/WB_BUSY/WB_WAIT_STALL, ZeroWord, Stop/NoStop, and the defaults for TIMEOUT and CNT_W.
- No sub-module: a single FSM with its datapath registers.
- The identical instruction-side bridge is a second instance of this same module, with we/dat tied off.

Test Plan:
- Load, ack after 3 cycles: cpu_ce=1, we=0, adr=0x80000010, stall=0, wb_dat_i=0xDEADBEEF.
  → cyc/stb high for exactly 3 cycles; stallreq=1 for 3 cycles; cpu_data_o=0xDEADBEEF in the ack cycle; next cycle IDLE.
- Store, ack next cycle: we=1, sel=4'b0011, dat=0x0000A5A5.
  → wb_we_o=1, wb_sel_o=0011, wb_dat_o=0x0000A5A5 for 1 cycle; rd_buf unchanged; cpu_data_o=0.
- Load acked while stall=6'b000111, stall released 2 cycles later.
  → WAIT_STALL for 2 cycles with cpu_data_o=0x12345678 held; stallreq=0; no new cyc.
- Flush at cycle 2 of BUSY without ack.
  → cyc/stb=0 next edge; rd_buf=0; stallreq=0; bus_err_o stays 0; a late ack in IDLE is ignored.
- TIMEOUT=4, no ack.
  → cyc high 4 cycles; bus_err_o=1 for exactly one cycle; back to IDLE.
  → With TIMEOUT=0 and no ack, the bridge holds BUSY for 300 cycles.
- rst asserted in BUSY with ack and flush asserted together.
  → All outputs 0 next cycle, regardless of ack/flush.
